lsu_subword: RTL and testbench

- MEM-stage load/store unit sitting directly upstream of the word-wide data memory, which has a synchronous write, an asynchronous read and no byte enables.
- Converts RV32I LB/LBU/LH/LHU/LW/SB/SH/SW requests into word accesses.
  - Loads: sign/zero extension.
  - Sub-word stores: 2-cycle read-modify-write, with a pipeline stall.
- Misaligned accesses either raise an error or are split into two word accesses (optional feature).

---
 rtl/lsu_subword_if.sv | 28 ++
 rtl/lsu_subword.sv | 207 ++++++++++++++++++++
 tb/tb_lsu_subword.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_subword_if.sv
// Request, response and data-memory signals between the MEM stage and lsu_subword.
// slave is the LSU side; master is the pipeline/memory side that drives requests and read data.
interface lsu_subword_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  req_valid;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  stall;
  logic [31:0]           load_data;
  logic                  misaligned_err;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_din;
  logic [31:0]           mem_dout;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    output stall, load_data, misaligned_err, mem_we, mem_addr, mem_din
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    input  stall, load_data, misaligned_err, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/lsu_subword.sv
// RV32I sub-word load/store to a word-wide memory: loads 0 cycles, SB/SH 1-cycle RMW stall.
// With LSU_MISALIGNED_SPLIT_EN misaligned loads stall 1 cycle and stores 3; otherwise they raise misaligned_err.
module lsu_subword #(
  parameter int ADDR_WIDTH = 10
) (
  input logic          clk,
  input logic          rst,
  lsu_subword_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RMW_WR
`ifdef LSU_MISALIGNED_SPLIT_EN
    , S_LD_HI,
    S_ST_LO_WR,
    S_ST_HI_RD,
    S_ST_HI_WR
`endif
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_wdat;

  logic [ADDR_WIDTH-1:0] w_idx;
  logic [1:0]            w_lane;
  logic                  w_is_b;
  logic                  w_is_h;
  logic                  w_is_w;
  logic                  w_mis;
  logic [3:0]            w_be;
  logic [3:0]            w_be_lo;
  logic [31:0]           w_dat_lo;
  logic [31:0]           w_merge_lo;
  logic                  w_unused_addr;

  function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] dat,
                                          input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~m) | (dat & m);
  endfunction

  function automatic logic [31:0] f_extend(input logic [31:0] w, input logic [1:0] sz,
                                           input logic uns);
    case (sz)
      2'b00:   return uns ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      2'b01:   return uns ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  assign w_idx         = bus.req_addr[ADDR_WIDTH+1:2];
  assign w_lane        = bus.req_addr[1:0];
  assign w_unused_addr = ^bus.req_addr[31:ADDR_WIDTH+2];
  assign w_is_b        = (bus.req_funct3[1:0] == 2'b00);
  assign w_is_h        = (bus.req_funct3[1:0] == 2'b01);
  assign w_is_w        = !w_is_b && !w_is_h;
  assign w_mis         = (w_is_h && w_lane[0]) || (w_is_w && (w_lane != 2'b00));
  assign w_be          = w_is_b ? 4'b0001 : (w_is_h ? 4'b0011 : 4'b1111);

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic [31:0] r_lo_word;
  logic [1:0]  r_lane;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [3:0]  r_hi_be;
  logic [31:0] r_hi_dat;
  logic [7:0]  w_be_all;
  logic [63:0] w_dat_all;
  logic [63:0] w_ld_cat;

  // Byte enables and data laid out across words N (low half) and N+1 (high half).
  assign w_be_all  = {4'b0000, w_be} << w_lane;
  assign w_dat_all = {32'h0, bus.req_wdata} << {w_lane, 3'b000};
  assign w_be_lo   = w_be_all[3:0];
  assign w_dat_lo  = w_dat_all[31:0];
  assign w_ld_cat  = {bus.mem_dout, r_lo_word};
`else
  assign w_be_lo   = w_be << w_lane;
  assign w_dat_lo  = bus.req_wdata << {w_lane, 3'b000};
`endif

  assign w_merge_lo = f_merge(bus.mem_dout, w_dat_lo, w_be_lo);

  always_comb begin
    bus.stall          = 1'b0;
    bus.load_data      = 32'h0;
    bus.misaligned_err = 1'b0;
    bus.mem_we         = 1'b0;
    bus.mem_addr       = w_idx;
    bus.mem_din        = bus.req_wdata;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (w_mis) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
            bus.stall = 1'b1;
`else
            bus.misaligned_err = 1'b1;
`endif
          end else if (bus.req_we) begin
            bus.mem_we = w_is_w;
            bus.stall  = !w_is_w;
          end else begin
            bus.load_data = f_extend(bus.mem_dout >> {w_lane, 3'b000},
                                     bus.req_funct3[1:0], bus.req_funct3[2]);
          end
        end
      end
      S_RMW_WR: begin
        bus.mem_we   = 1'b1;
        bus.mem_addr = r_idx;
        bus.mem_din  = r_wdat;
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      S_LD_HI: begin
        bus.mem_addr  = r_idx;
        bus.load_data = f_extend(w_ld_cat[{r_lane, 3'b000} +: 32], r_size, r_uns);
      end
      S_ST_LO_WR: begin
        bus.mem_we   = 1'b1;
        bus.mem_addr = r_idx;
        bus.mem_din  = r_wdat;
        bus.stall    = 1'b1;
      end
      S_ST_HI_RD: begin
        bus.mem_addr = r_idx;
        bus.stall    = 1'b1;
      end
      S_ST_HI_WR: begin
        bus.mem_we   = 1'b1;
        bus.mem_addr = r_idx;
        bus.mem_din  = r_wdat;
      end
`endif
      default: ;
    endcase
    // Reset must also squash a pending RMW write in the same cycle.
    if (rst) begin
      bus.stall          = 1'b0;
      bus.load_data      = 32'h0;
      bus.misaligned_err = 1'b0;
      bus.mem_we         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_wdat    <= 32'h0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      r_lo_word <= 32'h0;
      r_lane    <= 2'b00;
      r_size    <= 2'b00;
      r_uns     <= 1'b0;
      r_hi_be   <= 4'h0;
      r_hi_dat  <= 32'h0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid && !w_mis && bus.req_we && !w_is_w) begin
            r_idx   <= w_idx;
            r_wdat  <= w_merge_lo;
            r_state <= S_RMW_WR;
          end
`ifdef LSU_MISALIGNED_SPLIT_EN
          if (bus.req_valid && w_mis) begin
            if (bus.req_we) begin
              r_idx    <= w_idx;
              r_wdat   <= w_merge_lo;
              r_hi_be  <= w_be_all[7:4];
              r_hi_dat <= w_dat_all[63:32];
              r_state  <= S_ST_LO_WR;
            end else begin
              r_idx     <= w_idx + 1'b1;
              r_lo_word <= bus.mem_dout;
              r_lane    <= w_lane;
              r_size    <= bus.req_funct3[1:0];
              r_uns     <= bus.req_funct3[2];
              r_state   <= S_LD_HI;
            end
          end
`endif
        end
        S_RMW_WR: r_state <= S_IDLE;
`ifdef LSU_MISALIGNED_SPLIT_EN
        S_LD_HI: r_state <= S_IDLE;
        S_ST_LO_WR: begin
          r_idx   <= r_idx + 1'b1;
          r_state <= S_ST_HI_RD;
        end
        S_ST_HI_RD: begin
          r_wdat  <= f_merge(bus.mem_dout, r_hi_dat, r_hi_be);
          r_state <= S_ST_HI_WR;
        end
        S_ST_HI_WR: r_state <= S_IDLE;
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_subword.sv
// Randomised bench for lsu_subword against a byte-addressed little-endian memory model.
module tb_lsu_subword;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int TOTAL = DEPTH * 4;
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;

  logic [31:0] mem   [DEPTH];
  logic [7:0]  ref_b [TOTAL];

  lsu_subword_if #(.ADDR_WIDTH(AW)) bus ();

  lsu_subword #(.ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_dout = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_word(input int k);
    return {ref_b[4*k+3], ref_b[4*k+2], ref_b[4*k+1], ref_b[4*k]};
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] v;
    int          nb;
    int          base;
    v    = 32'h0;
    nb   = nbytes(f3);
    base = int'(a[AW+1:0]);
    for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_b[(base + i) % TOTAL];
    if (!f3[2] && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!f3[2] && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input int nb, input logic [31:0] d);
    int base;
    base = int'(a[AW+1:0]);
    for (int i = 0; i < nb; i++) ref_b[(base + i) % TOTAL] = d[8*i +: 8];
  endtask

  task automatic poke(input int k, input logic [31:0] v);
    mem[k] = v;
    for (int i = 0; i < 4; i++) ref_b[4*k+i] = v[8*i +: 8];
  endtask

  // Drives one request (entered at posedge+1) and holds it until stall drops.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    int          nb;
    int          stalls;
    int          exp_stalls;
    bit          mis;
    bit          done;
    logic        got_err;
    logic        got_we;
    logic [31:0] got_ld;
    nb  = nbytes(f3);
    mis = (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    stalls  = 0;
    done    = 1'b0;
    got_err = 1'b0;
    got_we  = 1'b0;
    got_ld  = 32'h0;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge clk);
      if (bus.stall) begin
        stalls++;
        @(posedge clk);
        #1;
      end else begin
        got_err = bus.misaligned_err;
        got_we  = bus.mem_we;
        got_ld  = bus.load_data;
        done    = 1'b1;
      end
    end
    chk("complete", {31'h0, done}, 32'h1);
    if (mis) exp_stalls = SPLIT ? (we ? 3 : 1) : 0;
    else     exp_stalls = (we && nb < 4) ? 1 : 0;
    chk("stall_cycles", stalls, exp_stalls);
    chk("misaligned_err", {31'h0, got_err}, {31'h0, mis && !SPLIT});
    chk("mem_we_final", {31'h0, got_we}, {31'h0, we && !(mis && !SPLIT)});
    if (!we) chk("load_data", got_ld, (mis && !SPLIT) ? 32'h0 : model_load(a, f3));
    else if (!(mis && !SPLIT)) model_store(a, nb, wd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic [31:0] a);
    logic [AW-1:0] exp_idx;
    exp_idx = a[AW+1:2];
    bus.req_valid = 1'b0;
    bus.req_addr  = a;
    bus.req_we    = a[5];
    @(negedge clk);
    chk("idle_stall", {31'h0, bus.stall}, 32'h0);
    chk("idle_we", {31'h0, bus.mem_we}, 32'h0);
    chk("idle_ld", bus.load_data, 32'h0);
    chk("idle_addr", {{(32-AW){1'b0}}, bus.mem_addr}, {{(32-AW){1'b0}}, exp_idx});
    @(posedge clk);
    #1;
  endtask

  task automatic check_mem(input string tag);
    for (int k = 0; k < DEPTH; k++) chk(tag, mem[k], ref_word(k));
  endtask

  initial begin
    logic [2:0] f3_tab [8];
    logic [31:0] ra;
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    n_chk = 0;
    n_bad = 0;
    for (int k = 0; k < DEPTH; k++) poke(k, 32'h0);

    // Reset with an active load request: all outputs forced quiet.
    rst = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h0C;
    bus.req_wdata  = 32'h0;
    poke(3, 32'h1122_3344);
    @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'h0, bus.stall}, 32'h0);
    chk("rst_we", {31'h0, bus.mem_we}, 32'h0);
    chk("rst_err", {31'h0, bus.misaligned_err}, 32'h0);
    chk("rst_ld", bus.load_data, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    issue(1'b0, 3'b010, 32'h0C, 32'h0);
    poke(1, 32'hAABB_CCDD);
    issue(1'b1, 3'b000, 32'h05, 32'h0000_00EE);
    chk("sb_word", mem[1], 32'hAABB_EEDD);
    issue(1'b0, 3'b100, 32'h05, 32'h0);
    issue(1'b0, 3'b000, 32'h07, 32'h0);
    poke(1, 32'h0);
    issue(1'b1, 3'b001, 32'h06, 32'h0000_1234);
    issue(1'b1, 3'b001, 32'h04, 32'h0000_5678);
    chk("sh_pair", mem[1], 32'h1234_5678);

    // Reset during the RMW write cycle drops the write.
    poke(2, 32'hCAFE_F00D);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h08;
    bus.req_wdata  = 32'h55;
    @(negedge clk);
    chk("rmw_rst_stall", {31'h0, bus.stall}, 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rmw_rst_we", {31'h0, bus.mem_we}, 32'h0);
    chk("rmw_rst_stall0", {31'h0, bus.stall}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_rst_mem", mem[2], 32'hCAFE_F00D);
    chk("rmw_rst_we_after", {31'h0, bus.mem_we}, 32'h0);
    @(posedge clk);
    #1;

    poke(3, 32'h4433_2211);
    poke(4, 32'h8877_6655);
    issue(1'b0, 3'b010, 32'h0D, 32'h0);
    poke(DEPTH - 1, 32'h1357_9BDF);
    poke(0, 32'h2468_ACE0);
    issue(1'b1, 3'b010, 32'((DEPTH - 1) * 4 + 2), 32'hDEAD_BEEF);
    check_mem("wrap_mem");

    for (int n = 0; n < 400; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 4) == 0) idle_cycle(ra);
      else issue(1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 7)], ra, $urandom);
    end
    check_mem("final_mem");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
